aq_mmu_sysmap_arb: RTL
======================

Name: aq_mmu_sysmap_arb

Overview:
Arbitrates and sequences access to the single combinational sysmap attribute lookup among up to N MMU-side requesters (default: ITLB refill, DTLB refill, PTW).
- Registers the winning physical page address and drives it to the sysmap lookup.
- Captures the returned 5-bit attribute flag and holds it until the granted requester acknowledges.
- Sits in the MMU between the TLB/PTW refill paths and the sysmap lookup.

Parameters:
REQ_NUM, 3, number of requesters (2..4).
PA_W, 28, page-address width (`PA_WIDTH-12).
FLG_W, 5, sysmap attribute flag width.

Ports:
forever_cpuclk  input  1  core clock; all state on rising edge.
cpurst  input  1  asynchronous, active-high reset.
mmu_arb_flush  input  1  kill in-flight lookup (sfence/pipeline flush).
req_vld  input  REQ_NUM  per-requester lookup request; held until accepted.
req_pa  input  REQ_NUM*PA_W  per-requester page address; slice i = bits [i*PA_W +: PA_W].
req_rdy  output  REQ_NUM  one-hot accept, combinational.
rsp_vld  output  REQ_NUM  one-hot response valid to the granted requester.
rsp_flg  output  FLG_W  registered sysmap flag, shared by all requesters.
rsp_ack  input  REQ_NUM  requester consumes the response.
arb_sysmap_pa  output  PA_W  registered address driven to the sysmap lookup.
sysmap_arb_flg  input  FLG_W  combinational flag returned by the sysmap lookup.
arb_busy  output  1  high whenever state != IDLE.

Behaviour:
- State machine: IDLE -> LOOKUP -> RESP -> IDLE. Encoded 2 bits; the unused code returns to IDLE.
- IDLE grant selection:
  - Round-robin from rr_ptr: first i in order rr_ptr, rr_ptr+1, ... (mod REQ_NUM) with req_vld[i]=1 wins.
  - req_rdy[grant]=1 only in IDLE, and only when mmu_arb_flush=0.
- On accept (req_vld & req_rdy):
  - pa_reg <= req_pa slice, gnt_id <= grant, rr_ptr <= grant+1, wrapping REQ_NUM-1 -> 0.
  - Next state is LOOKUP.
- LOOKUP: arb_sysmap_pa = pa_reg; flg_reg <= sysmap_arb_flg at the end of the cycle; next state is RESP.
- RESP:
  - rsp_vld[gnt_id]=1, all other bits 0; rsp_flg = flg_reg.
  - rsp_ack[gnt_id] -> IDLE next cycle. Ack bits for non-granted requesters are ignored.
  - Held indefinitely without ack; rsp_flg stays stable.
- Latency: accept at cycle T, rsp_vld at T+2. Earliest next accept is the cycle after ack (IDLE), giving one lookup per 3 cycles.
- arb_sysmap_pa is always pa_reg (no combinational bypass). pa_reg is updated only on accept.
- rsp_vld, req_rdy, arb_busy are pure functions of state plus inputs; no glitch paths from sysmap_arb_flg.
- Flush:
  - mmu_arb_flush=1 in any state -> IDLE next cycle.
  - rsp_vld is forced to 0 in the flush cycle; no req_rdy in the flush cycle.
  - rr_ptr, pa_reg, flg_reg are unchanged. The flushed requester must re-request.
- Simultaneous flush and rsp_ack: flush wins (same result: IDLE).
- Reset (async, any state): state=IDLE, rr_ptr=0, gnt_id=0, pa_reg=0, flg_reg=0.
  - Hence req_rdy=0 if no request, rsp_vld=0, rsp_flg=0, arb_sysmap_pa=0, arb_busy=0.
  - Mid-RESP reset drops the response silently.
- req_vld withdrawn before accept: legal, no effect. A requester whose request is accepted must not change req_pa in that cycle (sampled at the edge).

Test Plan:
1. After reset, req_vld=3'b001, req_pa[0]=28'h0000123 (inside no sysmap region) -> req_rdy=3'b001 at T; arb_sysmap_pa=28'h0000123 at T+1; rsp_vld=3'b001 with rsp_flg=5'b10011 at T+2; ack at T+2 -> arb_busy=0 at T+3.
2. req_vld=3'b111 held, immediate acks -> grants in order 0,1,2,0; each grant 3 cycles apart; rr_ptr wraps 2->0.
3. Address in sysmap region 3 on requester 2 -> rsp_flg equals configured SYSMAP_FLG3. Withhold rsp_ack 10 cycles -> rsp_vld=3'b100 and rsp_flg stable all 10 cycles. rsp_ack=3'b001 during hold is ignored.
4. mmu_arb_flush pulsed in LOOKUP -> no rsp_vld ever for that request; state IDLE next cycle; re-request of requester 1 served with correct flag; next RR start unchanged (ptr = last grant+1).
5. cpurst asserted asynchronously mid-RESP -> rsp_vld, arb_busy, arb_sysmap_pa, rsp_flg all 0 immediately. After release with req_vld=3'b110 -> requester 1 granted first (rr_ptr=0, first active).
6. Flush and rsp_ack in the same RESP cycle, with req_vld[0]=1 -> no req_rdy that cycle; IDLE next; requester 0 accepted the following cycle.

Source files
------------

// File: rtl/aq_mmu_sysmap_arb.sv
// Round-robin arbiter that serialises MMU requesters onto the single sysmap
// attribute lookup: register the page address, capture the flag, hold until ack.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for a request; req_rdy offered to the RR winner
//   ST_LOOKUP | r_pa drives the sysmap; flag captured at end of cycle
//   ST_RESP   | rsp_vld to r_gnt_id with r_flg until that requester acks
module aq_mmu_sysmap_arb #(
    parameter int REQ_NUM = 3,
    parameter int PA_W    = 28,
    parameter int FLG_W   = 5
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst,
    input  logic                    mmu_arb_flush,
    input  logic [REQ_NUM-1:0]      req_vld,
    input  logic [REQ_NUM*PA_W-1:0] req_pa,
    output logic [REQ_NUM-1:0]      req_rdy,
    output logic [REQ_NUM-1:0]      rsp_vld,
    output logic [FLG_W-1:0]        rsp_flg,
    input  logic [REQ_NUM-1:0]      rsp_ack,
    output logic [PA_W-1:0]         arb_sysmap_pa,
    input  logic [FLG_W-1:0]        sysmap_arb_flg,
    output logic                    arb_busy
);

    localparam int ID_W = (REQ_NUM > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOOKUP = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    localparam logic [REQ_NUM-1:0] ONE_HOT0 = {{(REQ_NUM-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_gnt_id;
    logic [PA_W-1:0]   r_pa;
    logic [FLG_W-1:0]  r_flg;

    logic [ID_W:0]     w_idx;
    logic [ID_W-1:0]   w_gnt;
    logic [ID_W-1:0]   w_gnt_nxt;
    logic              w_found;
    logic              w_accept;
    logic              w_ack_hit;

    // Scan from r_rr_ptr upward, wrapping at REQ_NUM; first active request wins.
    always_comb begin
        w_idx   = '0;
        w_gnt   = '0;
        w_found = 1'b0;
        for (int k = 0; k < REQ_NUM; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_idx >= (ID_W+1)'(REQ_NUM))
                w_idx = w_idx - (ID_W+1)'(REQ_NUM);
            if (!w_found && req_vld[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_idx[ID_W-1:0];
            end
        end
    end

    assign w_gnt_nxt = (w_gnt == ID_W'(REQ_NUM-1)) ? '0 : w_gnt + ID_W'(1);

    assign req_rdy = (r_state == ST_IDLE && !mmu_arb_flush && w_found)
                     ? (ONE_HOT0 << w_gnt) : '0;
    assign rsp_vld = (r_state == ST_RESP && !mmu_arb_flush)
                     ? (ONE_HOT0 << r_gnt_id) : '0;
    assign w_accept      = |(req_vld & req_rdy);
    assign w_ack_hit     = rsp_ack[r_gnt_id];
    assign rsp_flg       = r_flg;
    assign arb_sysmap_pa = r_pa;
    assign arb_busy      = (r_state != ST_IDLE);

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_gnt_id <= '0;
            r_pa     <= '0;
            r_flg    <= '0;
        end else if (mmu_arb_flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_pa     <= req_pa[int'(w_gnt)*PA_W +: PA_W];
                        r_gnt_id <= w_gnt;
                        r_rr_ptr <= w_gnt_nxt;
                        r_state  <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    r_flg   <= sysmap_arb_flg;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_ack_hit)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
